// File: rtl/gen_sel_arbiter.sv
// N-way arbiter sharing one registered update datapath (q = d or d + 1).
// Fixed-priority or round-robin policy, with a bounded grant lock.
module gen_sel_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MODE     = 1,
  parameter int INC      = 0,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          lock,
  input  logic [N*W-1:0]        data_in,
  output logic [N-1:0]          gnt,
  output logic                  gnt_valid,
  output logic [$clog2(N)-1:0]  gnt_idx,
  output logic [W-1:0]          q_out,
  output logic                  q_valid
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [W-1:0]    q_out_q, q_out_d;
  logic            q_valid_q, q_valid_d;

  logic [N-1:0]    cand;
  logic            keep;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    upd_data;

  // The holder only competes when nobody else is asking.
  always_comb begin
    keep = (state_q == GRANT) && req[gnt_idx_q] && lock[gnt_idx_q] &&
           (hold_cnt_q < HOLD_LAST);
    cand = ((req & ~gnt_q) != '0) ? (req & ~gnt_q) : req;
  end

  if (MODE == 0) begin : g_fixed
    always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end
  end else begin : g_rr
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          new_grant;

    // Walk backwards so the smallest offset from the pointer wins.
    always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = N - 1; off >= 0; off--) begin
        if (cand[(int'(rr_ptr_q) + off) % N]) begin
          win_found = 1'b1;
          win_idx   = IW'((int'(rr_ptr_q) + off) % N);
        end
      end
    end

    assign new_grant = !keep && win_found;

    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (new_grant) begin
        rr_ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    if (keep) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end else if (win_found) begin
      state_d    = GRANT;
      gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_idx;
      gnt_idx_d  = win_idx;
      hold_cnt_d = '0;
    end else begin
      state_d    = IDLE;
      gnt_d      = '0;
      gnt_idx_d  = '0;
      hold_cnt_d = '0;
    end
  end

  assign sel_data = data_in[int'(gnt_idx_q) * W +: W];

  if (INC != 0) begin : g_inc
    assign upd_data = sel_data + W'(1);
  end else begin : g_pass
    assign upd_data = sel_data;
  end

  always_comb begin
    q_valid_d = |gnt_q;
    q_out_d   = (|gnt_q) ? upd_data : q_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      hold_cnt_q <= '0;
      q_out_q    <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      q_out_q    <= q_out_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign q_out     = q_out_q;
  assign q_valid   = q_valid_q;

endmodule
